// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_seq_pkg
//  Brief    : Shared types for the I2C command sequencer: FSM state encoding
//             and the 16-bit queued command word {addr[15:9], rw[8], data[7:0]}.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    localparam int CMD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic [6:0] addr,
                                      input logic       rw,
                                      input logic [7:0] data);
        cmd_t c;
        c.addr = addr;
        c.rw   = rw;
        c.data = data;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_fifo
//  Brief    : DEPTH x WIDTH synchronous FIFO with first-word-fall-through head.
//             Push while full and pop while empty are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     i2c_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge i2c_clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge i2c_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_sequencer
//  Brief    : Queues host I2C transactions and issues them one at a time to
//             i2c_master_fsm; captures read bytes into a valid/ready register.
//             Optional wait-phase watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                     i2c_clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [6:0]               cmd_addr,
    input  logic                     cmd_rw,
    input  logic [7:0]               cmd_data,
    output logic [$clog2(DEPTH):0]   cmd_level,
    output logic [6:0]               m_addr,
    output logic                     m_rw,
    output logic [7:0]               m_data_in,
    output logic                     m_enable,
    input  logic                     m_ready,
    input  logic [7:0]               m_data_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     busy,
    output logic                     err_timeout
);

    state_t state;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    logic   wait_expired;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i2c_clk   (i2c_clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (pack_cmd(cmd_addr, cmd_rw, cmd_data)),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (cmd_level)
    );

    // The head is consumed in the same cycle it is loaded into the master-facing registers
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty && m_ready;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_flag;
    logic          in_wait;

    assign in_wait      = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign wait_expired = in_wait && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout  = timeout_flag;

    // Per-phase watchdog: restarts on entering each wait state, latches a sticky error on expiry
    always_ff @(posedge i2c_clk) begin
        if (!reset_n) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (wait_expired) timeout_flag <= 1'b1;
            if (!in_wait || wait_expired || ((state == S_WAIT_BUSY) && !m_ready))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + TW'(1);
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    // Transaction sequencing with registered master-side and response outputs
    always_ff @(posedge i2c_clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_data_in <= '0;
            m_enable  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        m_addr    <= head.addr;
                        m_rw      <= head.rw;
                        m_data_in <= head.data;
                        m_enable  <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_enable <= 1'b0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (wait_expired)  state <= S_IDLE;
                    else if (!m_ready) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (wait_expired) begin
                        state <= S_IDLE;
                    end else if (m_ready) begin
                        if (m_rw) begin
                            rsp_data  <= m_data_out;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i2c_cmd_sequencer
//  Brief    : Self-checking bench for i2c_cmd_sequencer: queue-based reference
//             model, behavioural I2C master, scoreboarded issue/response checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          i2c_clk    = 1'b0;
    logic          reset_n    = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic [6:0]    cmd_addr   = '0;
    logic          cmd_rw     = 1'b0;
    logic [7:0]    cmd_data   = '0;
    logic          m_ready    = 1'b1;
    logic [7:0]    m_data_out = '0;
    logic          rsp_ready  = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_level;
    logic [6:0]    m_addr;
    logic          m_rw;
    logic [7:0]    m_data_in;
    logic          m_enable;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic          busy;
    logic          err_timeout;

    i2c_cmd_sequencer #(
        .DEPTH (DEPTH)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .i2c_clk     (i2c_clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_rw      (cmd_rw),
        .cmd_data    (cmd_data),
        .cmd_level   (cmd_level),
        .m_addr      (m_addr),
        .m_rw        (m_rw),
        .m_data_in   (m_data_in),
        .m_enable    (m_enable),
        .m_ready     (m_ready),
        .m_data_out  (m_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 i2c_clk = ~i2c_clk;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } tcmd_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    tcmd_t       fifo_q[$];
    logic [7:0]  exp_rsp[$];

    // master-model knobs and state
    bit          stall      = 0;
    bit          hang       = 0;
    bit          force_data = 0;
    bit          long_hold  = 0;
    bit          mbusy      = 0;
    int          hold       = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Behavioural master: drops ready after enable, returns it some cycles later with data
    always @(negedge i2c_clk) begin
        if (!reset_n) begin
            mbusy   = 0;
            hold    = 0;
            m_ready = !stall;
        end else if (m_enable) begin
            mbusy      = 1;
            m_ready    = 1'b0;
            hold       = hang ? 1000000 : (long_hold ? 12 : int'($urandom_range(1, 6)));
            m_data_out = force_data ? 8'h3C : 8'($urandom);
            if (m_rw && !hang) exp_rsp.push_back(m_data_out);
        end else if (mbusy) begin
            if (hold > 0) hold--;
            else begin
                mbusy   = 0;
                m_ready = 1'b1;
            end
        end else begin
            m_ready = !stall;
        end
    end

    // Monitor / scoreboard: reference queue updated from the inputs seen at each edge
    logic       prev_en = 1'b0;
    logic       prev_rv = 1'b0;
    logic [7:0] last_rsp = '0;

    always @(posedge i2c_clk) begin
        int    pre_size;
        tcmd_t c;
        #1;
        if (!reset_n) begin
            fifo_q.delete();
            exp_rsp.delete();
            check("rst_m_enable",  m_enable,  0);
            check("rst_m_addr",    m_addr,    0);
            check("rst_m_rw",      m_rw,      0);
            check("rst_m_data_in", m_data_in, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data",  rsp_data,  0);
            check("rst_cmd_level", cmd_level, 0);
            check("rst_busy",      busy,      0);
            check("rst_err",       err_timeout, 0);
            prev_en = 1'b0;
            prev_rv = 1'b0;
        end else begin
            pre_size = fifo_q.size();
            if (cmd_valid && pre_size < DEPTH) fifo_q.push_back({cmd_addr, cmd_rw, cmd_data});
            if (m_enable) begin
                check("issue_pulse_width",       prev_en, 0);
                check("issue_while_rsp_pending", prev_rv, 0);
                check("issue_while_master_busy", mbusy,   0);
                if (pre_size == 0) begin
                    fail("issue_from_empty_queue");
                end else begin
                    c = fifo_q.pop_front();
                    check("issue_addr", m_addr, c.addr);
                    check("issue_rw",   m_rw,   c.rw);
                    if (!c.rw) check("issue_data", m_data_in, c.data);
                end
            end
            if (rsp_valid && !prev_rv) begin
                if (exp_rsp.size() == 0) fail("unexpected_rsp");
                else check("rsp_data", rsp_data, exp_rsp.pop_front());
                last_rsp = rsp_data;
            end else if (rsp_valid) begin
                check("rsp_data_hold", rsp_data, last_rsp);
            end
            if (prev_rv && !rsp_ready) check("rsp_held",    rsp_valid, 1);
            if (prev_rv &&  rsp_ready) check("rsp_cleared", rsp_valid, 0);
            check("cmd_level", cmd_level, fifo_q.size());
            check("cmd_ready", cmd_ready, (fifo_q.size() < DEPTH) ? 1 : 0);
            if (fifo_q.size() != 0) check("busy_with_queue", busy, 1);
`ifndef I2C_SEQ_TIMEOUT_EN
            check("err_timeout_tied", err_timeout, 0);
`endif
            prev_en = m_enable;
            prev_rv = rsp_valid;
        end
    end

    task automatic push(input logic [6:0] a, input logic r, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = r;
        cmd_data  = d;
        @(negedge i2c_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!(fifo_q.size() == 0 && !mbusy && !rsp_valid && !busy) && n < 500) begin
            @(negedge i2c_clk);
            n++;
        end
        if (n >= 500) fail(nm);
    endtask

    initial begin
        int n;
        int en_cnt;

        repeat (3) @(negedge i2c_clk);
        reset_n = 1'b1;
        @(negedge i2c_clk);

        // single write: enable two cycles after the push
        push(7'h50, 1'b0, 8'hA5);
        check("wr_lat_n1_enable", m_enable, 0);
        @(negedge i2c_clk);
        check("wr_lat_n2_enable", m_enable, 1);
        check("wr_m_addr",        m_addr,    7'h50);
        check("wr_m_data_in",     m_data_in, 8'hA5);
        wait_idle("idle_after_write");

        // two reads with response back-pressure
        rsp_ready  = 1'b0;
        force_data = 1;
        push(7'h51, 1'b1, 8'h00);
        push(7'h52, 1'b1, 8'h00);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge i2c_clk); n++; end
        if (n >= 50) fail("rsp_valid_timeout");
        check("rd_rsp_data", rsp_data, 8'h3C);
        en_cnt = 0;
        repeat (8) begin
            @(negedge i2c_clk);
            if (m_enable) en_cnt++;
            check("rd_rsp_hold_valid", rsp_valid, 1);
        end
        check("bp_no_second_issue", en_cnt, 0);
        check("bp_level_one_queued", cmd_level, 1);
        wait_idle("idle_after_reads");
        force_data = 0;

        // fill while master stalled: fifth push dropped
        stall = 1;
        repeat (2) @(negedge i2c_clk);
        for (int i = 0; i < 5; i++) push(7'(8'h10 + i), 1'b0, 8'(i));
        check("full_level", cmd_level, DEPTH);
        check("full_ready", cmd_ready, 0);
        stall = 0;
        wait_idle("idle_after_full");

        // reset while a read waits for the master, two more queued
        long_hold = 1;
        push(7'h30, 1'b1, 8'h00);
        push(7'h31, 1'b1, 8'h00);
        push(7'h32, 1'b1, 8'h00);
        n = 0;
        while (!mbusy && n < 20) begin @(negedge i2c_clk); n++; end
        if (n >= 20) fail("reset_test_issue_timeout");
        repeat (3) @(negedge i2c_clk);
        check("pre_reset_level", cmd_level, 2);
        reset_n = 1'b0;
        repeat (2) @(negedge i2c_clk);
        reset_n   = 1'b1;
        long_hold = 0;
        en_cnt = 0;
        repeat (10) begin
            @(negedge i2c_clk);
            if (m_enable) en_cnt++;
        end
        check("post_reset_no_enable", en_cnt, 0);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_busy",      busy, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // master never returns: watchdog fires, next command still issues
        hang = 1;
        push(7'h20, 1'b0, 8'h11);
        push(7'h21, 1'b0, 8'h22);
        n = 0;
        while (!mbusy && n < 20) begin @(negedge i2c_clk); n++; end
        if (n >= 20) fail("timeout_test_issue_timeout");
        repeat (10) @(negedge i2c_clk);
        check("timeout_not_early", err_timeout, 0);
        n = 0;
        while (!err_timeout && n < 40) begin @(negedge i2c_clk); n++; end
        check("timeout_set", err_timeout, 1);
        check("timeout_dut_idle_queue", cmd_level, 1);
        hang = 0;
        hold = 0;
        wait_idle("idle_after_timeout");
        check("timeout_sticky", err_timeout, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_addr  = 7'($urandom);
            cmd_rw    = 1'($urandom);
            cmd_data  = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge i2c_clk);
        end
        cmd_valid = 1'b0;
        wait_idle("idle_after_random");
        check("final_rsp_queue_empty", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #300000;
        fail("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
